// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner.
// Shows a 3-digit BCD window and a sign digit, snapshotting inputs once per frame.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int LZ_BLANK    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] left,
    input  logic [3:0] middle,
    input  logic [3:0] right,
    input  logic       sign,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    typedef enum logic [1:0] {
        S0,
        S1,
        S2,
        S3
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0] counter;
    logic          tick;

    logic [3:0] shadow_left;
    logic [3:0] shadow_middle;
    logic [3:0] shadow_right;
    logic       shadow_sign;

    logic       blank_left;
    logic       blank_middle;
    logic [3:0] anode_d;
    logic [6:0] seg_d;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    assign tick = (counter == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
        end else if (tick) begin
            counter <= '0;
        end else begin
            counter <= counter + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (tick) begin
            unique case (state)
                S0: next_state = S1;
                S1: next_state = S2;
                S2: next_state = S3;
                S3: next_state = S0;
            endcase
        end
    end

    // Frame boundary is the only point where new input values are accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_left   <= '0;
            shadow_middle <= '0;
            shadow_right  <= '0;
            shadow_sign   <= 1'b0;
        end else if (tick && state == S3) begin
            shadow_left   <= left;
            shadow_middle <= middle;
            shadow_right  <= right;
            shadow_sign   <= sign;
        end
    end

    assign blank_left   = (LZ_BLANK != 0) && (shadow_left == 4'd0);
    assign blank_middle = blank_left && (shadow_middle == 4'd0);

    always_comb begin
        anode_d = 4'b1110;
        seg_d   = SEG_BLANK;
        unique case (state)
            S0: begin
                anode_d = 4'b1110;
                seg_d   = bcd_to_seg(shadow_right);
            end
            S1: begin
                anode_d = 4'b1101;
                seg_d   = blank_middle ? SEG_BLANK : bcd_to_seg(shadow_middle);
            end
            S2: begin
                anode_d = 4'b1011;
                seg_d   = blank_left ? SEG_BLANK : bcd_to_seg(shadow_left);
            end
            S3: begin
                anode_d = 4'b0111;
                seg_d   = shadow_sign ? SEG_MINUS : SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            anode <= 4'b1110;
            seg   <= 7'b1000000;
        end else begin
            anode <= anode_d;
            seg   <= seg_d;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV = 4.
// Runs one blanking and one non-blanking instance side by side.
module tb_seven_seg_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] left;
    logic [3:0] middle;
    logic [3:0] right;
    logic       sign;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] anode0;
    logic [6:0] seg0;
    logic       dp0;

    int passed;
    int total;
    int k;
    bit mon_en;

    seven_seg_scanner #(.REFRESH_DIV(4), .LZ_BLANK(1)) dut (
        .clk(clk), .rst(rst), .left(left), .middle(middle),
        .right(right), .sign(sign), .anode(anode), .seg(seg), .dp(dp)
    );

    seven_seg_scanner #(.REFRESH_DIV(4), .LZ_BLANK(0)) dut0 (
        .clk(clk), .rst(rst), .left(left), .middle(middle),
        .right(right), .sign(sign), .anode(anode0), .seg(seg0), .dp(dp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exactly one anode low on every cycle after reset.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            total++;
            if (anode inside {4'b1110, 4'b1101, 4'b1011, 4'b0111})
                passed++;
            else
                $display("FAIL onehot: anode %b is not one-hot-zero at t=%0t", anode, $time);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
    endtask

    task automatic go_to(input int t);
        step(t - k);
    endtask

    task automatic chk(input string name, input logic [3:0] ea, input logic [6:0] es,
                       input logic [6:0] es0);
        total++;
        if (anode !== ea || seg !== es || anode0 !== ea || seg0 !== es0) begin
            $display("FAIL %s: anode %b/%b seg %b seg0 %b, expected anode %b seg %b seg0 %b",
                     name, anode, anode0, seg, seg0, ea, es, es0);
        end else begin
            passed++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        left = 4'd0; middle = 4'd0; right = 4'd0; sign = 1'b0;
        step(2);
        total++;
        if (anode !== 4'b1110 || seg !== 7'b1000000 || dp !== 1'b1 || dp0 !== 1'b1)
            $display("FAIL reset: anode %b seg %b dp %b, expected 1110 1000000 1",
                     anode, seg, dp);
        else
            passed++;
        rst = 1'b0;
        k = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_scan_sequence;
        logic [3:0] amap [4];
        logic [3:0] ea;
        amap[0] = 4'b1110; amap[1] = 4'b1101; amap[2] = 4'b1011; amap[3] = 4'b0111;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            ea = amap[((i - 1) / 4) % 4];
            total++;
            if (anode !== ea)
                $display("FAIL scan[%0d]: anode %b expected %b", i, anode, ea);
            else
                passed++;
        end
    endtask

    task automatic test_frame_values;
        left = 4'd3; middle = 4'd7; right = 4'd5; sign = 1'b1;
        go_to(33);
        chk("val_an0", 4'b1110, 7'b0010010, 7'b0010010);
        go_to(37);
        chk("val_an1", 4'b1101, 7'b1111000, 7'b1111000);
        go_to(41);
        chk("val_an2", 4'b1011, 7'b0110000, 7'b0110000);
        go_to(45);
        chk("val_an3", 4'b0111, 7'b0111111, 7'b0111111);
    endtask

    task automatic test_snapshot;
        go_to(53);
        right = 4'd9;
        left = 4'd8;
        go_to(57);
        chk("no_tear_an2", 4'b1011, 7'b0110000, 7'b0110000);
        go_to(63);
        middle = 4'd2;
        go_to(65);
        chk("snap_an0", 4'b1110, 7'b0010000, 7'b0010000);
        go_to(69);
        chk("tick_cycle_an1", 4'b1101, 7'b0100100, 7'b0100100);
        go_to(73);
        chk("snap_an2", 4'b1011, 7'b0000000, 7'b0000000);
    endtask

    task automatic test_blanking;
        left = 4'd0; middle = 4'd0; right = 4'd0; sign = 1'b0;
        go_to(77);
        chk("sign_held", 4'b0111, 7'b0111111, 7'b0111111);
        go_to(81);
        chk("zero_an0", 4'b1110, 7'b1000000, 7'b1000000);
        go_to(85);
        chk("zero_an1", 4'b1101, 7'b1111111, 7'b1000000);
        go_to(89);
        chk("zero_an2", 4'b1011, 7'b1111111, 7'b1000000);
        go_to(93);
        chk("zero_an3", 4'b0111, 7'b1111111, 7'b1111111);
        middle = 4'd4;
        go_to(101);
        chk("mid4_an1", 4'b1101, 7'b0011001, 7'b0011001);
        go_to(105);
        chk("mid4_an2", 4'b1011, 7'b1111111, 7'b1000000);
    endtask

    task automatic test_invalid_bcd;
        right = 4'd12;
        go_to(113);
        chk("bcd12_an0", 4'b1110, 7'b1111111, 7'b1111111);
    endtask

    task automatic test_reset_mid_frame;
        go_to(121);
        rst = 1'b1;
        step(1);
        chk("midrst", 4'b1110, 7'b1000000, 7'b1000000);
        rst = 1'b0;
        k = 0;
        step(4);
        chk("midrst_s0_hold", 4'b1110, 7'b1000000, 7'b1000000);
        step(1);
        chk("midrst_s1", 4'b1101, 7'b1111111, 7'b1000000);
    endtask

    initial begin
        passed = 0;
        total = 0;
        k = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        left = 4'd0; middle = 4'd0; right = 4'd0; sign = 1'b0;
        test_reset;
        test_scan_sequence;
        test_frame_values;
        test_snapshot;
        test_blanking;
        test_invalid_bcd;
        test_reset_mid_frame;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
